// File: rtl/exmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// exmem_arb_pkg
// Shared definitions for the exmem port arbiter: FSM state encoding, the data
// word returned on a timed-out access, and the fixed requester slot numbers.
// -----------------------------------------------------------------------------
package exmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Read data handed back when exmem never acknowledges an access.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Requester slot assignment on the request vectors.
    localparam int REQ_CPU   = 0;
    localparam int REQ_FIR   = 1;
    localparam int REQ_MM    = 2;
    localparam int REQ_QSORT = 3;

endpackage

// File: rtl/exmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// exmem_arbiter_if
// Bundles the requester side (packed per-requester request fields, ack/err,
// read data, grant) and the exmem side (valid/ack handshake) of the arbiter.
//   master : the arbiter (drives mem_* requests and req_* responses)
//   slave  : the surrounding requesters and exmem model
// Requester i occupies sel[4i+3:4i], adr[AW*i+AW-1:AW*i], dat[DW*i+DW-1:DW*i].
// -----------------------------------------------------------------------------
interface exmem_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_we_i;
    logic [4*N_REQ-1:0]  req_sel_i;
    logic [AW*N_REQ-1:0] req_adr_i;
    logic [DW*N_REQ-1:0] req_dat_i;
    logic [N_REQ-1:0]    req_ack_o;
    logic [N_REQ-1:0]    req_err_o;
    logic [DW-1:0]       req_dat_o;
    logic [N_REQ-1:0]    grant_o;

    logic                mem_valid_o;
    logic                mem_we_o;
    logic [3:0]          mem_sel_o;
    logic [AW-1:0]       mem_adr_o;
    logic [DW-1:0]       mem_dat_o;
    logic                mem_ack_i;
    logic [DW-1:0]       mem_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
        output req_ack_o, req_err_o, req_dat_o, grant_o,
        output mem_valid_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o,
        input  mem_ack_i, mem_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
        input  req_ack_o, req_err_o, req_dat_o, grant_o,
        input  mem_valid_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o,
        output mem_ack_i, mem_dat_i
    );

endinterface

// File: rtl/exmem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational rotating-priority picker. The search starts just above the
// last owner and wraps, so the most recent owner has the lowest priority.
//   req_i  : request vector
//   last_i : index of the previous owner
//   gnt_o  : one-hot winner (0 when no request)
//   idx_o  : index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int pos;
        gnt_o = '0;
        idx_o = '0;
        pos   = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last_i) + k) % N;
            if (req_i[pos]) begin
                gnt_o      = '0;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/exmem_arbiter.sv
// -----------------------------------------------------------------------------
// exmem_arbiter
// Round-robin arbiter sharing the single exmem port between the CPU Wishbone
// path and the FIR / matmul / qsort DMA masters. One winner is latched per
// access, driven to exmem, and its ack/read data returned one cycle after
// exmem acks. A BUSY-cycle counter completes the access with an error and
// TIMEOUT_DATA if exmem never responds (TIMEOUT = 0 disables it).
//   wb_clk_i : clock
//   wb_rst_i : asynchronous active-low reset
//   bus      : requester + exmem signals (master modport)
// -----------------------------------------------------------------------------
module exmem_arbiter
    import exmem_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    exmem_arbiter_if.master bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    arb_state_e     state;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  own_idx;
    logic [CW-1:0]  cnt;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             win_we;
    logic [3:0]       win_sel;
    logic [AW-1:0]    win_adr;
    logic [DW-1:0]    win_dat;
    logic             timeout_hit;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req_i  (bus.req_valid_i),
        .last_i (last_grant),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // Steer the winning requester's fields to the mem_* latches.
    always_comb begin
        win_we  = 1'b0;
        win_sel = '0;
        win_adr = '0;
        win_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_we  = bus.req_we_i[i];
                win_sel = bus.req_sel_i[4*i +: 4];
                win_adr = bus.req_adr_i[AW*i +: AW];
                win_dat = bus.req_dat_i[DW*i +: DW];
            end
        end
    end

    // The counter sits at TIMEOUT on the (TIMEOUT+1)-th BUSY cycle; an ack in
    // that same cycle still takes precedence.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_MAX);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state           <= IDLE;
            last_grant      <= IW'(N_REQ - 1);
            own_idx         <= '0;
            cnt             <= '0;
            bus.grant_o     <= '0;
            bus.req_ack_o   <= '0;
            bus.req_err_o   <= '0;
            bus.req_dat_o   <= '0;
            bus.mem_valid_o <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_sel_o   <= '0;
            bus.mem_adr_o   <= '0;
            bus.mem_dat_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid_i) begin
                        bus.mem_we_o    <= win_we;
                        bus.mem_sel_o   <= win_sel;
                        bus.mem_adr_o   <= win_adr;
                        bus.mem_dat_o   <= win_dat;
                        bus.mem_valid_o <= 1'b1;
                        bus.grant_o     <= pick_gnt;
                        own_idx         <= pick_idx;
                        cnt             <= '0;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack_i) begin
                        bus.req_dat_o   <= bus.mem_dat_i;
                        bus.req_ack_o   <= bus.grant_o;
                        bus.req_err_o   <= '0;
                        bus.mem_valid_o <= 1'b0;
                        state           <= RESP;
                    end else if (timeout_hit) begin
                        bus.req_dat_o   <= DW'(TIMEOUT_DATA);
                        bus.req_ack_o   <= bus.grant_o;
                        bus.req_err_o   <= bus.grant_o;
                        bus.mem_valid_o <= 1'b0;
                        state           <= RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Requests seen here are ignored; arbitration resumes in IDLE.
                    bus.req_ack_o <= '0;
                    bus.req_err_o <= '0;
                    bus.grant_o   <= '0;
                    last_grant    <= own_idx;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exmem_arbiter.sv
module tb_exmem_arbiter;
    import exmem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exmem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

    exmem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // requester state
    logic        act   [N];
    logic        we_a  [N];
    logic [3:0]  sel_a [N];
    logic [31:0] adr_a [N];
    logic [31:0] dat_a [N];

    // exmem responder control: -1 = random latency/data
    int          lat_mode = 0;
    logic [31:0] fix_dat  = 32'h0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid_i[i]         = act[i];
            bus.req_we_i[i]            = we_a[i];
            bus.req_sel_i[4*i +: 4]    = sel_a[i];
            bus.req_adr_i[AW*i +: AW]  = adr_a[i];
            bus.req_dat_i[DW*i +: DW]  = dat_a[i];
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        act[i] = 1'b1; we_a[i] = we; sel_a[i] = 4'hF; adr_a[i] = adr; dat_a[i] = dat;
    endtask

    task automatic drop(input int i);
        @(posedge clk); #1;
        act[i] = 1'b0;
        drive_reqs();
    endtask

    // Count negedges until req_ack_o is seen; vrise = first negedge with mem_valid_o.
    task automatic wait_ack(output int n, output int vrise);
        n = 0; vrise = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (vrise == 0 && bus.mem_valid_o) vrise = c;
            if (bus.req_ack_o != '0) begin
                n = c;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ack_wait: no req_ack_o within 60 cycles");
    endtask

    // ---------------- exmem responder ----------------
    initial begin : responder
        int   cnt;
        logic in_txn;
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        in_txn = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack_i = 1'b0;
            if (!rst_n || !bus.mem_valid_o) begin
                in_txn = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cnt = (lat_mode < 0) ? int'($urandom_range(0, 6)) : lat_mode;
                end
                if (cnt == 0) begin
                    bus.mem_ack_i = 1'b1;
                    bus.mem_dat_i = (lat_mode < 0) ? $urandom : fix_dat;
                    cnt = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    function automatic int rr_pick(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++)
            if (r[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    logic [N-1:0] p_grant, p_req;
    logic         p_valid, p_mack, p_we, p_ea;
    logic [31:0]  p_mdat;
    int           p_vcnt;
    int           last;

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg;
        logic         ea, ee, ev;
        int           w;
        if (!rst_n) begin
            p_grant = '0; p_valid = 1'b0; p_mack = 1'b0; p_we = 1'b0; p_ea = 1'b0;
            p_mdat = '0; p_vcnt = 0; last = N - 1;
            p_req = bus.req_valid_i;
        end else begin
            // completion: exmem ack, or TIMEOUT+1 valid cycles without one
            ea = p_valid && (p_mack || (p_vcnt == TO + 1));
            ee = ea && !p_mack;
            chk("ack", 32'(bus.req_ack_o), 32'(ea ? p_grant : '0));
            chk("err", 32'(bus.req_err_o), 32'(ee ? p_grant : '0));
            if (ea && !p_we) chk("rdata", bus.req_dat_o, ee ? 32'hDEAD_BEEF : p_mdat);

            if (p_grant == '0) begin
                w  = rr_pick(p_req, last);
                eg = (w < 0) ? '0 : (N'(1) << w);
            end else if (p_ea) begin
                eg = '0;
            end else begin
                eg = p_grant;
            end
            chk("grant", 32'(bus.grant_o), 32'(eg));
            ev = (eg != '0) && !ea;
            chk("mem_valid", 32'(bus.mem_valid_o), 32'(ev));

            p_we = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (eg[i]) begin
                    if (ev) begin
                        chk("mem_adr", bus.mem_adr_o, bus.req_adr_i[AW*i +: AW]);
                        chk("mem_we",  32'(bus.mem_we_o),  32'(bus.req_we_i[i]));
                        chk("mem_sel", 32'(bus.mem_sel_o), 32'(bus.req_sel_i[4*i +: 4]));
                        chk("mem_dat", bus.mem_dat_o, bus.req_dat_i[DW*i +: DW]);
                    end
                    p_we = bus.req_we_i[i];
                end
                if (ea && p_grant[i]) last = i;
            end

            p_ea    = ea;
            p_grant = eg;
            p_valid = ev;
            p_vcnt  = ev ? p_vcnt + 1 : 0;
            p_mack  = bus.mem_ack_i;
            p_mdat  = bus.mem_dat_i;
            p_req   = bus.req_valid_i;
        end
    end

    // ---------------- stimulus ----------------
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n, vr;

    task automatic reset_dut();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; we_a[i] = 1'b0; sel_a[i] = '0; adr_a[i] = '0; dat_a[i] = '0;
        end
        drive_reqs();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",   32'(bus.req_ack_o), 32'h0);
        chk("rst_err",   32'(bus.req_err_o), 32'h0);
        chk("rst_rdat",  bus.req_dat_o, 32'h0);
        chk("rst_grant", 32'(bus.grant_o), 32'h0);
        chk("rst_valid", 32'(bus.mem_valid_o), 32'h0);
        chk("rst_adr",   bus.mem_adr_o, 32'h0);
        #1 rst_n = 1'b1;

        // single CPU read, ack on third valid cycle
        lat_mode = 2; fix_dat = 32'h1234_5678;
        @(posedge clk); #1;
        set_req(REQ_CPU, 1'b0, 32'h3800_0010, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        chk("t1_vrise", vr, 2);
        chk("t1_lat",   n, 5);
        chk("t1_ack",   32'(bus.req_ack_o), 32'h1);
        chk("t1_err",   32'(bus.req_err_o), 32'h0);
        chk("t1_rdat",  bus.req_dat_o, 32'h1234_5678);
        drop(REQ_CPU);

        // all four held from reset, single-cycle exmem
        lat_mode = 0; fix_dat = 32'h0BAD_0000;
        reset_dut();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h3800_0100 + 32'(i) * 32'h10, 32'(i));
        drive_reqs();
        for (int j = 0; j < 5; j++) begin
            wait_ack(n, vr);
            chk("t2_order", 32'(bus.req_ack_o), 32'(1) << exp_order[j]);
            chk("t2_thru",  n, 3);
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        drive_reqs();

        // after 2 is served, 1 and 3 together: 3 then 1
        @(posedge clk); #1;
        set_req(REQ_MM, 1'b1, 32'h3800_0200, 32'hAAAA_0002);
        drive_reqs();
        wait_ack(n, vr);
        chk("t3_mm", 32'(bus.req_ack_o), 32'h4);
        drop(REQ_MM);
        @(posedge clk); #1;
        set_req(REQ_FIR, 1'b0, 32'h3800_0300, 32'h0);
        set_req(REQ_QSORT, 1'b0, 32'h3800_0400, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        chk("t3_first", 32'(bus.req_ack_o), 32'h8);
        drop(REQ_QSORT);
        wait_ack(n, vr);
        chk("t3_second", 32'(bus.req_ack_o), 32'h2);
        drop(REQ_FIR);

        // exmem never acks: error completion after TIMEOUT+1 valid cycles
        lat_mode = 1000;
        @(posedge clk); #1;
        set_req(REQ_CPU, 1'b0, 32'h3800_0500, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        chk("t4_vrise", vr, 2);
        chk("t4_lat",   n, 7);
        chk("t4_ack",   32'(bus.req_ack_o), 32'h1);
        chk("t4_err",   32'(bus.req_err_o), 32'h1);
        chk("t4_rdat",  bus.req_dat_o, 32'hDEAD_BEEF);
        drop(REQ_CPU);
        lat_mode = 1; fix_dat = 32'hA5A5_0001;
        @(posedge clk); #1;
        set_req(REQ_FIR, 1'b0, 32'h3800_0600, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        chk("t4_next_ack",  32'(bus.req_ack_o), 32'h2);
        chk("t4_next_err",  32'(bus.req_err_o), 32'h0);
        chk("t4_next_rdat", bus.req_dat_o, 32'hA5A5_0001);
        drop(REQ_FIR);

        // ack on exactly the timeout cycle
        lat_mode = TO; fix_dat = 32'hC0DE_0004;
        @(posedge clk); #1;
        set_req(REQ_QSORT, 1'b0, 32'h3800_0700, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        chk("t5_lat",  n, 7);
        chk("t5_err",  32'(bus.req_err_o), 32'h0);
        chk("t5_rdat", bus.req_dat_o, 32'hC0DE_0004);
        drop(REQ_QSORT);

        // reset while BUSY
        lat_mode = 0;
        @(posedge clk); #1;
        set_req(REQ_CPU, 1'b0, 32'h3800_0800, 32'h0);
        drive_reqs();
        wait_ack(n, vr);
        drop(REQ_CPU);
        lat_mode = 1000;
        @(posedge clk); #1;
        set_req(REQ_CPU, 1'b0, 32'h3800_0900, 32'h0);
        set_req(REQ_FIR, 1'b0, 32'h3800_0A00, 32'h0);
        drive_reqs();
        vr = 0;
        for (int c = 0; c < 10 && vr == 0; c++) begin
            @(negedge clk);
            if (bus.mem_valid_o) vr = 1;
        end
        chk("t6_busy", vr, 1);
        chk("t6_grant_before", 32'(bus.grant_o), 32'h2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(bus.mem_valid_o), 32'h0);
        chk("t6_grant_async", 32'(bus.grant_o), 32'h0);
        chk("t6_no_ack",      32'(bus.req_ack_o), 32'h0);
        lat_mode = 0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_ack(n, vr);
        chk("t6_first", 32'(bus.req_ack_o), 32'h1);
        drop(REQ_CPU);
        wait_ack(n, vr);
        chk("t6_second", 32'(bus.req_ack_o), 32'h2);
        drop(REQ_FIR);

        // randomized traffic against the model
        lat_mode = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (act[i] && bus.req_ack_o[i]) begin
                    act[i] = 1'b0;
                end else if (!act[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 32'h3800_0000 | ($urandom & 32'h00FF_FFFC), $urandom);
                    sel_a[i] = 4'($urandom_range(1, 15));
                end
            end
            drive_reqs();
        end
        // drain
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (act[i] && bus.req_ack_o[i]) act[i] = 1'b0;
            drive_reqs();
        end
        chk("drain_idle", 32'(bus.req_valid_i), 32'h0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exmem_arbiter.md
# exmem_arbiter

Round-robin arbiter that shares the single user-memory (`exmem`) port between four requesters: the CPU Wishbone path (decoded 0x38xx_xxxx accesses) and the DMA master ports of the FIR, matmul and qsort accelerators. It latches one winning request, drives it onto the `exmem` valid/ack interface, and returns the read data and ack to the winner. A timeout counter recovers the port if `exmem` never acks. It sits between the Wishbone decoder/accelerator wrappers and `exmem`.

## Interface
- `N_REQ`, 4, number of requesters (0=CPU, 1=FIR, 2=matmul, 3=qsort)
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, max BUSY cycles before error completion; 0 disables timeout

- `wb_clk_i` in 1: sole clock
- `wb_rst_i` in 1: reset, asynchronous, active-low
- `req_valid_i` in N_REQ: per-requester request, held until its ack
- `req_we_i` in N_REQ: 1=write
- `req_sel_i` in 4*N_REQ: byte enables, requester i at [4i+3:4i]
- `req_adr_i` in AW*N_REQ: address, requester i at [AW*i+AW-1:AW*i]
- `req_dat_i` in DW*N_REQ: write data, same packing
- `req_ack_o` out N_REQ: one-cycle completion pulse, at most one bit set
- `req_err_o` out N_REQ: set with ack on timeout completion
- `req_dat_o` out DW: read data, valid only while a `req_ack_o` bit is high
- `grant_o` out N_REQ: one-hot current owner, 0 in IDLE
- `mem_valid_o` out 1: request to `exmem`
- `mem_we_o` out 1, `mem_sel_o` out 4, `mem_adr_o` out AW, `mem_dat_o` out DW: latched request fields
- `mem_ack_i` in 1: `exmem` completion
- `mem_dat_i` in DW: `exmem` read data, valid with `mem_ack_i`

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any `req_valid_i` high, pick winner g = first set bit searching upward (with wrap) from `last_grant+1`; latch g's we/sel/adr/dat into the mem_* registers, set `grant_o[g]`, clear timeout counter, go BUSY. Else stay.
- BUSY: `mem_valid_o`=1, mem_* fields stable. Counter increments each cycle.
  - `mem_ack_i`=1: capture `mem_dat_i` into `req_dat_o`, go RESP with err=0.
  - Counter reaches TIMEOUT (TIMEOUT≠0) without ack: `req_dat_o`<=32'hDEAD_BEEF, go RESP with err=1.
  - Ack and timeout in the same cycle: ack wins, err=0.
- RESP: `mem_valid_o`=0, `req_ack_o[g]`=1, `req_err_o[g]`=err, `last_grant`<=g; next state IDLE. Requests sampled in RESP are ignored.
- Requester dropping `req_valid_i` during BUSY: transaction completes and acks normally (protocol violation, not aborted).
- Write data returned on `req_dat_o` for writes is don't-care; the bench checks only reads.
- Reset values: state IDLE, all outputs 0, `req_dat_o`=0, counter 0, `last_grant`=N_REQ-1 (requester 0 wins the first tie).
- Reset asserted mid-transaction: immediate return to IDLE, `mem_valid_o` drops asynchronously, no ack is issued, and the pending requester re-arbitrates after reset.

## Timing
- Request sampled in IDLE at cycle 0 -> `mem_valid_o` high from cycle 1.
- `mem_ack_i` sampled high at cycle k -> `mem_valid_o` low and `req_ack_o` high at cycle k+1 -> IDLE at k+2. Earliest next grant is sampled at k+2, so the earliest next `mem_valid_o` is at k+3.
- Single-cycle `exmem` (ack at cycle 1): 3-cycle throughput per access.
- Timeout: with no ack, `req_ack_o`+`req_err_o` appear TIMEOUT+1 cycles after `mem_valid_o` rises.
- All outputs registered. No combinational path from `mem_*` inputs to `req_*` outputs.

## Structure
- Package `exmem_arb_pkg`: state enum (IDLE/BUSY/RESP), `TIMEOUT_DATA`=32'hDEAD_BEEF, requester index constants (REQ_CPU=0, REQ_FIR=1, REQ_MM=2, REQ_QSORT=3).
- Sub-module `rr_picker`: combinational rotating-priority one-hot picker (inputs: request vector, last_grant; outputs: one-hot grant, index). It is reused by other shared-resource arbiters.
- Counter width $clog2(TIMEOUT+1).

## Test plan
- Single CPU read, `exmem` acks 2 cycles after valid with 0x1234_5678: `mem_valid_o` at cycle 1, `req_ack_o`=4'b0001 and `req_dat_o`=0x1234_5678 one cycle after ack, `req_err_o`=0.
- All four requesters held valid from reset with 1-cycle acks: grants in order 0,1,2,3,0; each ack one-hot; `mem_adr_o` equals the granted requester's address.
- After requester 2 is served, requesters 1 and 3 valid together: 3 wins, then 1.
- TIMEOUT=4, `exmem` never acks: `req_ack_o[g]` and `req_err_o[g]` pulse 5 cycles after `mem_valid_o` rises; `req_dat_o`=0xDEAD_BEEF; next request proceeds normally.
- `mem_ack_i` on exactly the timeout cycle: err=0 and data from `mem_dat_i`.
- Reset asserted in BUSY: `mem_valid_o` and `grant_o` drop immediately, no ack; after release requester 0 wins first.
